// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive buffer controller.
// The optional interrupt output of the controller is enabled with UART_RX_IRQ_EN.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLAG  = 2'd1,
        WAIT  = 2'd2,
        CLEAR = 2'd3
    } rx_state_t;

    localparam int UART_DATA_W = 8;
    localparam int UART_DEPTH  = 4;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through FIFO for received UART words; head is always visible on dout.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_CNT);
    assign do_pop = pop && !empty;
    // A slot freed by a simultaneous pop can take the incoming word.
    assign do_push = push && (!full || do_pop);

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_buffer_ctrl.sv
// UART receive controller: buffers words, hands them one at a time to the data register,
// and handshakes new_rx with software. Define UART_RX_IRQ_EN to add the irq_o pulse output.
module uart_rx_buffer_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rx_data_rdy,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_ack_i,
    output logic                     wr2,
    output logic                     hold_ctrl,
    output logic [DATA_W-1:0]        data_o,
    output logic                     we_reg_control,
    output logic                     new_rx,
    output logic                     overrun_o,
`ifdef UART_RX_IRQ_EN
    output logic                     irq_o,
`endif
    output logic [$clog2(DEPTH):0]   fifo_count_o
);

    rx_state_t         state_q, state_d;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              overrun_event;
    logic              overrun_q, overrun_d;
    logic              new_rx_q, new_rx_d;

    uart_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push   (rx_data_rdy),
        .pop    (fifo_pop),
        .din    (rx_data),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count_o)
    );

    always_comb begin
        state_d        = state_q;
        fifo_pop       = 1'b0;
        wr2            = 1'b0;
        hold_ctrl      = 1'b0;
        data_o         = '0;
        we_reg_control = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    wr2       = 1'b1;
                    hold_ctrl = 1'b1;
                    data_o    = fifo_dout;
                    state_d   = FLAG;
                end
            end
            FLAG: begin
                we_reg_control = 1'b1;
                state_d        = WAIT;
            end
            WAIT: begin
                if (rx_ack_i) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                we_reg_control = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A word arriving on a full FIFO is lost unless the FSM frees a slot this cycle.
    assign overrun_event = rx_data_rdy && fifo_full && !fifo_pop;

    always_comb begin
        overrun_d = overrun_q;
        if (rx_ack_i) begin
            overrun_d = 1'b0;
        end
        if (overrun_event) begin
            overrun_d = 1'b1;
        end
        new_rx_d = (state_d == FLAG) || (state_d == WAIT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            overrun_q <= 1'b0;
            new_rx_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_d;
            new_rx_q  <= new_rx_d;
        end
    end

    assign new_rx    = new_rx_q;
    assign overrun_o = overrun_q;

`ifdef UART_RX_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = ((state_d == FLAG) && (state_q != FLAG)) || (overrun_d && !overrun_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// Directed bench for uart_rx_buffer_ctrl (DATA_W=8, DEPTH=4); irq checks when UART_RX_IRQ_EN is defined.
module tb_uart_rx_buffer_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              rx_data_rdy;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ack_i;
    logic              wr2;
    logic              hold_ctrl;
    logic [DATA_W-1:0] data_o;
    logic              we_reg_control;
    logic              new_rx;
    logic              overrun_o;
`ifdef UART_RX_IRQ_EN
    logic              irq_o;
`endif
    logic [CNT_W-1:0]  fifo_count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    uart_rx_buffer_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rx_data_rdy    (rx_data_rdy),
        .rx_data        (rx_data),
        .rx_ack_i       (rx_ack_i),
        .wr2            (wr2),
        .hold_ctrl      (hold_ctrl),
        .data_o         (data_o),
        .we_reg_control (we_reg_control),
        .new_rx         (new_rx),
        .overrun_o      (overrun_o),
`ifdef UART_RX_IRQ_EN
        .irq_o          (irq_o),
`endif
        .fifo_count_o   (fifo_count_o)
    );

    // Inputs change and outputs are sampled right after the falling edge.
    task automatic step();
        @(negedge clk_i);
    endtask

    // From the IDLE cycle that shows wr2: FLAG, WAIT for a few cycles, ack, CLEAR, back to IDLE.
    task automatic ack_word();
        step();
        step();
        repeat (4) step();
        rx_ack_i = 1'b1;
        step();
        rx_ack_i = 1'b0;
        step();
    endtask

    // Bounded wait for the next hand-off to the data register.
    task automatic wait_wr2(output bit seen);
        int n;
        n = 0;
        while (wr2 !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        seen = (wr2 === 1'b1);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; rx_data_rdy = 1'b0; rx_data = '0; rx_ack_i = 1'b0;
        step(); step();
        rst_i = 1'b0;
        step();
        checks++; if ({wr2, hold_ctrl, we_reg_control, new_rx, overrun_o} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {wr2, hold_ctrl, we_reg_control, new_rx, overrun_o}); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_o); end
        checks++; if (fifo_count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count_o); end
    endtask

    task automatic test_single_word();
        rx_data_rdy = 1'b1; rx_data = 8'hA5;
        step();
        rx_data_rdy = 1'b0;
        checks++; if ({wr2, hold_ctrl} !== 2'b11) begin errors++; $display("FAIL single_wr2_hold: got %b expected 11", {wr2, hold_ctrl}); end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", data_o); end
        checks++; if (new_rx !== 1'b0) begin errors++; $display("FAIL single_new_rx_early: got %b expected 0", new_rx); end
        checks++; if (fifo_count_o !== 3'd1) begin errors++; $display("FAIL single_count_t1: got %0d expected 1", fifo_count_o); end
        step();
        checks++; if ({new_rx, we_reg_control, wr2} !== 3'b110) begin errors++; $display("FAIL single_flag: got %b expected 110", {new_rx, we_reg_control, wr2}); end
        checks++; if (fifo_count_o !== 3'd0) begin errors++; $display("FAIL single_count_t2: got %0d expected 0", fifo_count_o); end
        step();
        checks++; if ({new_rx, we_reg_control} !== 2'b10) begin errors++; $display("FAIL single_wait: got %b expected 10", {new_rx, we_reg_control}); end
        repeat (3) step();
        checks++; if (new_rx !== 1'b1) begin errors++; $display("FAIL single_held: got %b expected 1", new_rx); end
        rx_ack_i = 1'b1;
        step();
        rx_ack_i = 1'b0;
        checks++; if ({new_rx, we_reg_control} !== 2'b01) begin errors++; $display("FAIL single_clear: got %b expected 01", {new_rx, we_reg_control}); end
        step();
        checks++; if ({wr2, we_reg_control, new_rx} !== 3'b000) begin errors++; $display("FAIL single_idle: got %b expected 000", {wr2, we_reg_control, new_rx}); end
        $display("single word a5 handed off and acknowledged");
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_data [3];
        logic [CNT_W-1:0]  exp_cnt  [3];
        bit seen;
        exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
        exp_cnt[0]  = 3'd1;  exp_cnt[1]  = 3'd2;  exp_cnt[2]  = 3'd1;
        rx_data_rdy = 1'b1; rx_data = 8'h11;
        step();
        checks++; if (wr2 !== 1'b1 || data_o !== 8'h11) begin errors++; $display("FAIL b2b_first: got wr2=%b data=%h expected wr2=1 data=11", wr2, data_o); end
        rx_data = 8'h22;
        step();
        rx_data = 8'h33;
        step();
        rx_data_rdy = 1'b0;
        checks++; if (fifo_count_o !== 3'd2) begin errors++; $display("FAIL b2b_peak: got %0d expected 2", fifo_count_o); end
        repeat (5) step();
        rx_ack_i = 1'b1;
        step();
        rx_ack_i = 1'b0;
        step();
        for (int i = 1; i < 3; i++) begin
            wait_wr2(seen);
            checks++; if (!seen) begin errors++; $display("FAIL b2b_timeout_%0d: got no wr2 expected wr2", i); end
            checks++; if (data_o !== exp_data[i]) begin errors++; $display("FAIL b2b_data_%0d: got %h expected %h", i, data_o, exp_data[i]); end
            checks++; if (fifo_count_o !== exp_cnt[i]) begin errors++; $display("FAIL b2b_count_%0d: got %0d expected %0d", i, fifo_count_o, exp_cnt[i]); end
            $display("back-to-back word %0d: data %h", i, data_o);
            ack_word();
        end
        checks++; if (fifo_count_o !== 3'd0) begin errors++; $display("FAIL b2b_drained: got %0d expected 0", fifo_count_o); end
    endtask

    task automatic test_overrun();
        logic [DATA_W-1:0] exp_data [4];
        bit seen;
        exp_data[0] = 8'h03; exp_data[1] = 8'h04; exp_data[2] = 8'h05; exp_data[3] = 8'h07;
        for (int i = 1; i <= 6; i++) begin
            rx_data_rdy = 1'b1; rx_data = 8'(i);
            step();
            if (i == 1) begin
                checks++; if (wr2 !== 1'b1 || data_o !== 8'h01) begin errors++; $display("FAIL ovr_first: got wr2=%b data=%h expected wr2=1 data=01", wr2, data_o); end
            end
        end
        rx_data_rdy = 1'b0;
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun_o); end
        checks++; if (fifo_count_o !== 3'd4) begin errors++; $display("FAIL ovr_count: got %0d expected 4", fifo_count_o); end
        checks++; if (new_rx !== 1'b1) begin errors++; $display("FAIL ovr_new_rx: got %b expected 1", new_rx); end
`ifdef UART_RX_IRQ_EN
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL ovr_irq_pulse: got %b expected 1", irq_o); end
`endif
        step();
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun_o); end
`ifdef UART_RX_IRQ_EN
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL ovr_irq_end: got %b expected 0", irq_o); end
`endif
        rx_ack_i = 1'b1;
        step();
        rx_ack_i = 1'b0;
        checks++; if (overrun_o !== 1'b0 || we_reg_control !== 1'b1) begin errors++; $display("FAIL ovr_ack_clear: got ovr=%b we=%b expected ovr=0 we=1", overrun_o, we_reg_control); end
        step();
        checks++; if (wr2 !== 1'b1 || data_o !== 8'h02 || fifo_count_o !== 3'd4) begin errors++; $display("FAIL full_pop_head: got wr2=%b data=%h cnt=%0d expected wr2=1 data=02 cnt=4", wr2, data_o, fifo_count_o); end
        $display("overrun: word 02 handed off from full fifo");
        rx_data_rdy = 1'b1; rx_data = 8'h07;
        step();
        rx_data_rdy = 1'b0;
        checks++; if (fifo_count_o !== 3'd4) begin errors++; $display("FAIL full_push_pop_count: got %0d expected 4", fifo_count_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL full_push_pop_ovr: got %b expected 0", overrun_o); end
        step();
        rx_ack_i = 1'b1;
        step();
        rx_ack_i = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            wait_wr2(seen);
            checks++; if (!seen) begin errors++; $display("FAIL drain_timeout_%0d: got no wr2 expected wr2", i); end
            checks++; if (data_o !== exp_data[i]) begin errors++; $display("FAIL drain_data_%0d: got %h expected %h", i, data_o, exp_data[i]); end
            $display("overrun drain word %0d: data %h", i, data_o);
            ack_word();
        end
        checks++; if (fifo_count_o !== 3'd0 || overrun_o !== 1'b0) begin errors++; $display("FAIL drain_end: got cnt=%0d ovr=%b expected cnt=0 ovr=0", fifo_count_o, overrun_o); end
    endtask

    task automatic test_reset_in_wait();
        rx_data_rdy = 1'b1; rx_data = 8'hAA;
        step();
        rx_data = 8'hBB;
        step();
        rx_data = 8'hCC;
        step();
        rx_data_rdy = 1'b0;
        checks++; if (fifo_count_o !== 3'd2 || new_rx !== 1'b1) begin errors++; $display("FAIL rstwait_setup: got cnt=%0d new_rx=%b expected cnt=2 new_rx=1", fifo_count_o, new_rx); end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checks++; if ({wr2, hold_ctrl, we_reg_control, new_rx, overrun_o} !== 5'b0 || data_o !== 8'h00) begin errors++; $display("FAIL rstwait_outputs: got flags=%b data=%h expected flags=00000 data=00", {wr2, hold_ctrl, we_reg_control, new_rx, overrun_o}, data_o); end
        checks++; if (fifo_count_o !== 3'd0) begin errors++; $display("FAIL rstwait_count: got %0d expected 0", fifo_count_o); end
        step();
        checks++; if (wr2 !== 1'b0) begin errors++; $display("FAIL rstwait_discard: got wr2=%b expected 0", wr2); end
        $display("reset in WAIT discarded buffered words");
    endtask

`ifdef UART_RX_IRQ_EN
    task automatic test_irq();
        rx_data_rdy = 1'b1; rx_data = 8'h5A;
        step();
        rx_data_rdy = 1'b0;
        checks++; if (irq_o !== 1'b0 || data_o !== 8'h5A) begin errors++; $display("FAIL irq_before_flag: got irq=%b data=%h expected irq=0 data=5a", irq_o, data_o); end
        step();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_on_flag: got %b expected 1", irq_o); end
        step();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_single: got %b expected 0", irq_o); end
        rx_ack_i = 1'b1;
        step();
        rx_ack_i = 1'b0;
        step();
        $display("irq pulse for word 5a");
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; rx_data_rdy = 1'b0; rx_data = '0; rx_ack_i = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overrun();
        test_reset_in_wait();
`ifdef UART_RX_IRQ_EN
        test_irq();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
